barrel_shift_pipe: RTL

//   Pipelined bidirectional barrel shifter/rotator for the barrel-shifter project; the opposite-direction

---
 rtl/barrel_shift_pipe.sv | 87 ++++++++
 1 files changed

// File: rtl/barrel_shift_pipe.sv
// Pipelined right-move barrel shifter/rotator, one log2 stage per clock; left ops run the same
// datapath on bit-reversed operands and reverse the result in the last stage.
module barrel_shift_pipe #(
  parameter int N = 3,
  localparam int W = 2 ** N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [N-1:0] in_amt,
  input  logic [1:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  function automatic logic [W-1:0] reverse(input logic [W-1:0] d);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = d[W-1-i];
    return r;
  endfunction

  // Stage registers: element k holds the output of log-stage k plus the amt/op it travels with.
  logic [N-1:0][W-1:0] data_p;
  logic [N-1:0][N-1:0] amt_p;
  logic [N-1:0][1:0]   op_p;
  logic [N-1:0]        vld_p;

  logic [N-1:0][W-1:0] stg_in;
  logic [N-1:0][W-1:0] stg_out;
  logic [N-1:0][N-1:0] amt_in;
  logic [N-1:0][1:0]   op_in;
  logic                en;

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_p[N-1];
  assign out_data  = data_p[N-1];

  for (genvar k = 0; k < N; k++) begin : g_stage
    localparam int D = 1 << k;
    logic [W-1:0] moved;

    if (k == 0) begin : g_entry
      assign stg_in[k] = in_op[0] ? reverse(in_data) : in_data;
      assign amt_in[k] = in_amt;
      assign op_in[k]  = in_op;
    end else begin : g_link
      assign stg_in[k] = data_p[k-1];
      assign amt_in[k] = amt_p[k-1];
      assign op_in[k]  = op_p[k-1];
    end

    always_comb begin
      moved = stg_in[k];
      if (amt_in[k][k]) begin
        if (op_in[k][1]) moved = stg_in[k] >> D;
        else             moved = {stg_in[k][D-1:0], stg_in[k][W-1:D]};
      end
    end

    // The final stage undoes the entry reversal so out_data is already the finished result.
    if (k == N - 1) begin : g_exit
      assign stg_out[k] = op_in[k][0] ? reverse(moved) : moved;
    end else begin : g_mid
      assign stg_out[k] = moved;
    end
  end

  // ---- stage boundary: all N registers advance together on en ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_p <= '0;
      amt_p  <= '0;
      op_p   <= '0;
      vld_p  <= '0;
    end else if (en) begin
      data_p <= stg_out;
      amt_p  <= amt_in;
      op_p   <= op_in;
      vld_p  <= {vld_p[N-2:0], in_valid};
    end
  end

endmodule
